rat_io_bank: RTL
================

// Module: rat_io_bank
// PURPOSE
//  Parametrised I/O port bank and interrupt source for the RAT MCU.
//  - Decodes PORT_ID/IO_STRB into N_OUT output registers and N_IN synchronised input ports.
//  - Returns the selected input value on IN_PORT.
//  - Raises INT_CU when any unmasked input channel changes value.
//  Sits between RAT_MCU and board I/O, replacing hard-wired IN_PORT/OUT_PORT glue.
// PARAMETERS
//  DATA_W   8      width of data ports and of each channel
//  ID_W     8      width of PORT_ID
//  N_OUT    4      number of output registers, 1..16
//  N_IN     4      number of input channels, 1..DATA_W (one pending/mask bit each)
//  OUT_BASE 8'h40  PORT_ID of output register 0; register k is at OUT_BASE+k
//  IN_BASE  8'h20  PORT_ID of input channel 0; channel k is at IN_BASE+k
//  MASK_ID  8'hF0  interrupt mask register, read/write
//  PEND_ID  8'hF1  interrupt pending register, read / write-1-to-clear
// PORTS
//  CLK       in   1             system clock, all state on rising edge
//  RESET     in   1             synchronous reset, active-high
//  PORT_ID   in   ID_W          I/O address from MCU
//  OUT_PORT  in   DATA_W        write data from MCU
//  IO_STRB   in   1             write strobe from MCU, one cycle per OUT instruction
//  IN_DATA   in   N_IN*DATA_W   external inputs; channel k at [k*DATA_W +: DATA_W]
//  IN_PORT   out  DATA_W        read data to MCU
//  OUT_DATA  out  N_OUT*DATA_W  output register contents; same packing as IN_DATA
//  INT_CU    out  1             interrupt request to MCU, level, registered
// BEHAVIOUR
//  Reset
//  - On a CLK edge with RESET=1, all of the following clear to 0:
//    OUT_DATA, mask, pending, INT_CU, sync/prev flops, init counter.
//  - Applies mid-operation too: INT_CU is low after the first reset edge.
//  - An IO_STRB coincident with RESET is ignored.
//  Writes
//  - IO_STRB=1 & PORT_ID==OUT_BASE+k, k<N_OUT: OUT_DATA[k] <= OUT_PORT at that edge; 1-cycle latency.
//  - MASK_ID: mask <= OUT_PORT[N_IN-1:0].
//  - PEND_ID: clears pending bits where OUT_PORT bit = 1.
//  - Any other PORT_ID: write ignored, no state change.
//  Inputs
//  - Each channel passes through 2 flops (s1 -> s2); prev <= s2 every cycle.
//  - chg[k] = (s2[k] != prev[k]).
//  Read (combinational on PORT_ID, no strobe)
//  - IN_BASE+k, k<N_IN: s2[k].
//  - MASK_ID / PEND_ID: register value, zero-extended to DATA_W.
//  - Any other PORT_ID: 0.
//  Init guard
//  - 2-bit counter counts 0..3 after reset and saturates at 3.
//  - chg is suppressed while the counter < 3, so power-up values never set pending.
//  Pending update
//  - pending <= (pending & ~clr) | (chg & {N_IN{armed}}).
//  - A set and a clear on the same bit in the same cycle: set wins, bit stays 1.
//  - A channel that changes again while pending stays pending; no count is kept.
//  Interrupt
//  - INT_CU <= |(pending & mask); it is a level, held until pending is cleared or masked.
//  - Latency: IN_DATA change before edge E -> s1@E, s2@E+1, pending@E+2, INT_CU@E+3.
//  - Mask set while a bit is pending: INT_CU rises on the next edge.
//  Address map
//  - OUT, IN, MASK_ID and PEND_ID ranges must not overlap.
//  - An elaboration-time $error fires on overlap or on N_IN>DATA_W.
// TESTING
//  1. Reset: RESET=1 for 2 clk, IN_DATA=8'hA5 on all ch
//     -> OUT_DATA=0, INT_CU=0; pending stays 0 after release (init guard).
//  2. Output write: PORT_ID=8'h42, OUT_PORT=8'h3C, IO_STRB=1 one cycle
//     -> OUT_DATA[2]=8'h3C next edge; others unchanged; PORT_ID=8'h50 write ignored.
//  3. Input read: IN_DATA ch1=8'h7E
//     -> IN_PORT=8'h7E with PORT_ID=8'h21 from 2 edges later; PORT_ID=8'h99 -> IN_PORT=0.
//  4. Interrupt: mask<=8'h01, ch0 changes 8'h00->8'h11 before edge E
//     -> INT_CU=1 after E+3; ch1 change alone never raises INT_CU.
//  5. Clear race: write 8'h01 to PEND_ID in the same cycle ch0 chg=1
//     -> pending[0] stays 1, INT_CU stays 1; a later clear drops INT_CU next edge.
//  6. Reset mid-operation: INT_CU=1, assert RESET
//     -> INT_CU=0, mask=0, pending=0 after 1 edge; no interrupt for 3 cycles after release.

Source files
------------

// File: rtl/rat_io_bank.sv
// I/O port bank for the RAT MCU: strobed output registers, synchronised input ports,
// and a maskable change-detect interrupt with a post-reset init guard.
module rat_io_bank #(
  parameter int              DATA_W   = 8,
  parameter int              ID_W     = 8,
  parameter int              N_OUT    = 4,
  parameter int              N_IN     = 4,
  parameter logic [ID_W-1:0] OUT_BASE = 'h40,
  parameter logic [ID_W-1:0] IN_BASE  = 'h20,
  parameter logic [ID_W-1:0] MASK_ID  = 'hF0,
  parameter logic [ID_W-1:0] PEND_ID  = 'hF1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ID_W-1:0]         PORT_ID,
  input  logic [DATA_W-1:0]       OUT_PORT,
  input  logic                    IO_STRB,
  input  logic [N_IN*DATA_W-1:0]  IN_DATA,
  output logic [DATA_W-1:0]       IN_PORT,
  output logic [N_OUT*DATA_W-1:0] OUT_DATA,
  output logic                    INT_CU
);

  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + N_OUT - 1;
  localparam int IN_LO  = int'(IN_BASE);
  localparam int IN_HI  = IN_LO + N_IN - 1;
  localparam int MASK_I = int'(MASK_ID);
  localparam int PEND_I = int'(PEND_ID);

  localparam bit BAD_MAP =
      (N_IN > DATA_W) ||
      (OUT_LO <= IN_HI && IN_LO <= OUT_HI) ||
      (MASK_I >= OUT_LO && MASK_I <= OUT_HI) || (MASK_I >= IN_LO && MASK_I <= IN_HI) ||
      (PEND_I >= OUT_LO && PEND_I <= OUT_HI) || (PEND_I >= IN_LO && PEND_I <= IN_HI) ||
      (MASK_I == PEND_I);

  if (BAD_MAP) begin : g_bad_map
    $error("rat_io_bank: overlapping address map or N_IN > DATA_W");
  end

  logic [N_IN*DATA_W-1:0]  s1, s2, prev;
  logic [N_OUT*DATA_W-1:0] out_q;
  logic [N_IN-1:0]         mask, pending, chg, clr;
  logic [1:0]              init_cnt;
  logic                    armed;

  // Change detection stays off until the synchronisers hold real post-reset samples.
  assign armed = (init_cnt == 2'd3);

  always_comb begin
    chg = '0;
    for (int k = 0; k < N_IN; k++) begin
      chg[k] = armed && (s2[k*DATA_W +: DATA_W] != prev[k*DATA_W +: DATA_W]);
    end
  end

  assign clr = (IO_STRB && PORT_ID == PEND_ID) ? OUT_PORT[N_IN-1:0] : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      out_q    <= '0;
      mask     <= '0;
      pending  <= '0;
      INT_CU   <= 1'b0;
      init_cnt <= 2'd0;
    end else begin
      s1   <= IN_DATA;
      s2   <= s1;
      prev <= s2;
      if (init_cnt != 2'd3) init_cnt <= init_cnt + 2'd1;
      // A new change outranks a simultaneous write-1-to-clear.
      pending <= (pending & ~clr) | chg;
      INT_CU  <= |(pending & mask);
      if (IO_STRB && PORT_ID == MASK_ID) mask <= OUT_PORT[N_IN-1:0];
      for (int k = 0; k < N_OUT; k++) begin
        if (IO_STRB && PORT_ID == ID_W'(OUT_LO + k)) out_q[k*DATA_W +: DATA_W] <= OUT_PORT;
      end
    end
  end

  assign OUT_DATA = out_q;

  always_comb begin
    IN_PORT = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (PORT_ID == ID_W'(IN_LO + k)) IN_PORT = s2[k*DATA_W +: DATA_W];
    end
    if (PORT_ID == MASK_ID) IN_PORT = DATA_W'(mask);
    if (PORT_ID == PEND_ID) IN_PORT = DATA_W'(pending);
  end

endmodule
